// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
// Covers fetch state encodings, the queue entry layout and the bubble word.
package fetch_queue_pkg;

    localparam int INSTR_W = 32;
    localparam logic [31:0] PC_INC = 32'd4;
    localparam logic [INSTR_W-1:0] NOP_WORD = '0;

    typedef enum logic {
        FQ_FETCH = 1'b0,
        FQ_DROP  = 1'b1
    } fq_state_e;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry {pc, instr} queue with push, pop, clear and occupancy count.
// The head entry is always presented on a combinational read port.
module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic                      pop,
    input  logic                      clear,
    input  fq_entry_t                 wr_data,
    output fq_entry_t                 head,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W = $clog2(DEPTH);

    fq_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; an empty queue is never read because the top gates its outputs.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch unit: sequential fetch over a req/ack memory handshake,
// buffered in a small queue, with flush and redirect on a taken branch.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               im_req,
    output logic [31:0]        im_addr,
    input  logic               im_ack,
    input  logic [INSTR_W-1:0] im_rdata,
    input  logic               pc_src,
    input  logic [31:0]        pc_addr,
    input  logic               stall,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [31:0]        if_pc,
    output logic [31:0]        pc_p4
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fq_state_e        state, state_d;
    logic [31:0]      fetch_pc, fetch_pc_d;
    logic [31:0]      im_addr_d;
    logic             im_req_d;
    logic [CNT_W-1:0] count, count_d;
    logic             push, pop;
    fq_entry_t        head;

    assign if_valid = (count != '0);
    assign pop      = if_valid && !stall && !pc_src;
    // Returned data is only kept when it belongs to the current fetch stream.
    assign push     = im_req && im_ack && (state == FQ_FETCH) && !pc_src;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .clear   (pc_src),
        .wr_data ('{pc: fetch_pc, instr: im_rdata}),
        .head    (head),
        .count   (count)
    );

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d    = state;
        fetch_pc_d = fetch_pc;
        count_d    = count;

        if (pc_src) begin
            fetch_pc_d = pc_addr;
            state_d    = (im_req && !im_ack) ? FQ_DROP : FQ_FETCH;
            count_d    = '0;
        end else begin
            if (state == FQ_DROP && im_ack) state_d = FQ_FETCH;
            if (push) fetch_pc_d = fetch_pc + PC_INC;
            if (push && !pop)      count_d = count + 1'b1;
            else if (pop && !push) count_d = count - 1'b1;
        end

        // A waiting request keeps its address; count cannot rise while waiting.
        im_req_d  = (state_d == FQ_DROP) || (count_d < CNT_W'(DEPTH));
        im_addr_d = (state_d == FQ_DROP) ? im_addr : fetch_pc_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FQ_FETCH;
            fetch_pc <= RESET_PC;
            im_req   <= 1'b0;
            im_addr  <= RESET_PC;
        end else begin
            state    <= state_d;
            fetch_pc <= fetch_pc_d;
            im_req   <= im_req_d;
            im_addr  <= im_addr_d;
        end
    end

    assign if_pc    = if_valid ? head.pc : 32'h0;
    assign if_instr = if_valid ? head.instr : NOP_WORD;
    assign pc_p4    = if_valid ? head.pc + PC_INC : 32'h0;

endmodule
